// File: rtl/alu_mem_responder.sv
// alu_mem_responder: synthesizable memory model for the ALU MEM operand path.
// A request is accepted in IDLE, the addressed word is captured, and after a
// clamped delay the word is presented until the initiator acknowledges it.
//
// Handshakes:
//   - Request: a request is taken when REQ=1 at a rising edge while REQ_RDY=1.
//     REQ_RDY is high only in IDLE and never looks at REQ combinationally.
//   - Response: RSP_VLD stays high with RSP_DATA stable until RSP_ACK=1 at an edge.
//   - RSP_ACK while RSP_VLD=0 has no effect.
module alu_mem_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DELAY_MIN  = 1,
    parameter int DELAY_MAX  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    output logic                  REQ_RDY,
    input  logic [2:0]            CFG_DELAY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_VLD,
    input  logic                  RSP_ACK,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic [CNT_WIDTH-1:0]  RSP_CNT
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [2:0] DLY_MIN = 3'(DELAY_MIN);
    localparam logic [2:0] DLY_MAX = 3'(DELAY_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            dly_q, dly_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [2:0]            eff_delay;

    // Clamp the requested delay into the supported window.
    always_comb begin
        eff_delay = CFG_DELAY;
        if (CFG_DELAY < DLY_MIN) begin
            eff_delay = DLY_MIN;
        end else if (CFG_DELAY > DLY_MAX) begin
            eff_delay = DLY_MAX;
        end
    end

    // Next-state logic: accept, count down the delay, hold until ack.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    // mem_q holds the pre-edge contents, so a same-edge
                    // write to this address is not visible here.
                    data_d  = mem_q[REQ_ADDR];
                    dly_d   = eff_delay;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dly_q == 3'd1) begin
                    dly_d   = 3'd0;
                    state_d = S_RESP;
                end else begin
                    dly_d = dly_q - 3'd1;
                end
            end
            S_RESP: begin
                if (RSP_ACK) begin
                    state_d = S_IDLE;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand table: cleared by reset, preloaded through the write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (WR_EN) begin
            mem_q[WR_ADDR] <= WR_DATA;
        end
    end

    assign REQ_RDY  = (state_q == S_IDLE);
    assign RSP_VLD  = (state_q == S_RESP);
    assign RSP_DATA = (state_q == S_RESP) ? data_q : '0;
    assign RSP_CNT  = cnt_q;

endmodule

// File: tb/tb_alu_mem_responder.sv
// tb_alu_mem_responder: directed plus random transactions against a table
// and counter model; a second instance uses a 2-bit response counter.
module tb_alu_mem_responder;

    // Clock and reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST = 1'b1;
    logic       REQ = 1'b0;
    logic [3:0] REQ_ADDR = '0;
    logic [2:0] CFG_DELAY = '0;
    logic       RSP_ACK = 1'b0;
    logic       WR_EN = 1'b0;
    logic [3:0] WR_ADDR = '0;
    logic [7:0] WR_DATA = '0;

    logic        REQ_RDY, RSP_VLD;
    logic [7:0]  RSP_DATA;
    logic [15:0] RSP_CNT;
    logic        rdy2, vld2;
    logic [7:0]  data2;
    logic [1:0]  cnt2;

    alu_mem_responder dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_RDY(REQ_RDY),
        .CFG_DELAY(CFG_DELAY), .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD),
        .RSP_ACK(RSP_ACK), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RSP_CNT(RSP_CNT)
    );

    alu_mem_responder #(.CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_RDY(rdy2),
        .CFG_DELAY(CFG_DELAY), .RSP_DATA(data2), .RSP_VLD(vld2),
        .RSP_ACK(RSP_ACK), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RSP_CNT(cnt2)
    );

    // Reference model and scoreboard
    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  model_tbl [16];
    logic [15:0] model_cnt;
    logic [1:0]  model_cnt2;
    logic [7:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_delay(input int cfg);
        if (cfg < 1) return 1;
        if (cfg > 4) return 4;
        return cfg;
    endfunction

    // One clock: apply the edge's effect to the model, then settle.
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            foreach (model_tbl[i]) model_tbl[i] = 8'h00;
            model_cnt  = '0;
            model_cnt2 = '0;
        end else if (WR_EN) begin
            model_tbl[WR_ADDR] = WR_DATA;
        end
        #1;
    endtask

    // Driver tasks
    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) tick();
        RST = 1'b0;
        exp_q.delete();
        chk("rst_rdy", REQ_RDY, 1);
        chk("rst_vld", RSP_VLD, 0);
        chk("rst_data", RSP_DATA, 0);
        chk("rst_cnt", RSP_CNT, 0);
        chk("rst_cnt2", cnt2, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic xact(input logic [3:0] a, input logic [2:0] cfg, input int hold,
                        input bit hz_en, input logic [7:0] hz_d,
                        input bit wt_en, input logic [7:0] wt_d);
        int d;
        logic [7:0] exp_d;
        logic [7:0] held;
        d = eff_delay(int'(cfg));
        chk("rdy_before_req", REQ_RDY, 1);
        REQ = 1'b1; REQ_ADDR = a; CFG_DELAY = cfg;
        if (hz_en) begin
            WR_EN = 1'b1; WR_ADDR = a; WR_DATA = hz_d;
        end
        exp_q.push_back(model_tbl[a]);
        tick();
        REQ = 1'b0; WR_EN = 1'b0;
        CFG_DELAY = 3'($urandom_range(0, 7));
        for (int k = 1; k <= d; k++) begin
            chk("wait_vld", RSP_VLD, 0);
            chk("wait_data", RSP_DATA, 0);
            chk("wait_rdy", REQ_RDY, 0);
            RSP_ACK = 1'($urandom_range(0, 1));
            REQ = 1'($urandom_range(0, 1));
            if (wt_en && k == 1) begin
                WR_EN = 1'b1; WR_ADDR = a; WR_DATA = wt_d;
            end
            tick();
            WR_EN = 1'b0;
        end
        RSP_ACK = 1'b0; REQ = 1'b0;
        exp_d = exp_q.pop_front();
        chk("resp_vld", RSP_VLD, 1);
        chk("resp_data", RSP_DATA, exp_d);
        chk("resp_rdy", REQ_RDY, 0);
        chk("resp_data2", data2, exp_d);
        held = RSP_DATA;
        for (int h = 0; h < hold; h++) begin
            REQ = 1'($urandom_range(0, 1));
            REQ_ADDR = 4'($urandom_range(0, 15));
            WR_EN = 1'($urandom_range(0, 1));
            WR_ADDR = 4'($urandom_range(0, 15));
            WR_DATA = 8'($urandom_range(0, 255));
            tick();
            chk("hold_vld", RSP_VLD, 1);
            chk("hold_data", RSP_DATA, exp_d);
            chk("hold_stable", RSP_DATA, held);
            chk("hold_rdy", REQ_RDY, 0);
        end
        WR_EN = 1'b0;
        RSP_ACK = 1'b1;
        tick();
        RSP_ACK = 1'b0; REQ = 1'b0;
        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        if (model_cnt2 != 2'd3) model_cnt2 = model_cnt2 + 2'd1;
        chk("ack_vld", RSP_VLD, 0);
        chk("ack_data", RSP_DATA, 0);
        chk("ack_rdy", REQ_RDY, 1);
        chk("ack_rdy2", rdy2, 1);
        chk("ack_cnt", RSP_CNT, model_cnt);
        chk("ack_cnt2", cnt2, model_cnt2);
    endtask

    // Abandon a transaction with reset, either while waiting or responding.
    task automatic rst_mid(input logic [3:0] a, input logic [2:0] cfg, input bit in_resp);
        int d;
        d = eff_delay(int'(cfg));
        REQ = 1'b1; REQ_ADDR = a; CFG_DELAY = cfg;
        tick();
        REQ = 1'b0;
        if (in_resp) begin
            repeat (d) tick();
            chk("mid_in_resp", RSP_VLD, 1);
            chk("mid_in_resp2", vld2, 1);
        end else begin
            chk("mid_in_wait", RSP_VLD, 0);
            chk("mid_in_wait_rdy", REQ_RDY, 0);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_vld", RSP_VLD, 0);
        chk("mid_data", RSP_DATA, 0);
        chk("mid_rdy", REQ_RDY, 1);
        chk("mid_cnt", RSP_CNT, 0);
        chk("mid_cnt2", cnt2, 0);
    endtask

    // Stimulus
    initial begin
        // Reset and preload
        do_reset(3);
        wr(4'd3, 8'hA5);
        xact(4'd3, 3'd2, 0, 0, 8'h00, 0, 8'h00);
        chk("first_cnt", RSP_CNT, 1);

        // Delay clamping
        wr(4'd1, 8'h12); wr(4'd2, 8'h34); wr(4'd4, 8'h56);
        xact(4'd1, 3'd0, 0, 0, 8'h00, 0, 8'h00);
        xact(4'd2, 3'd7, 0, 0, 8'h00, 0, 8'h00);
        xact(4'd4, 3'd3, 0, 0, 8'h00, 0, 8'h00);

        // Backpressure
        wr(4'd6, 8'h5A);
        xact(4'd6, 3'd2, 10, 0, 8'h00, 0, 8'h00);

        // Write hazards
        wr(4'd5, 8'h11);
        xact(4'd5, 3'd2, 0, 1, 8'h3C, 1, 8'h77);
        xact(4'd5, 3'd1, 0, 0, 8'h00, 0, 8'h00);
        chk("hazard_model", model_tbl[5], 8'h77);

        // Reset mid-operation
        rst_mid(4'd3, 3'd4, 0);
        xact(4'd3, 3'd1, 0, 0, 8'h00, 0, 8'h00);
        wr(4'd3, 8'h42);
        rst_mid(4'd3, 3'd2, 1);
        xact(4'd3, 3'd2, 0, 0, 8'h00, 0, 8'h00);

        // Counter saturation on the 2-bit instance
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            xact(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 0, 0, 8'h00, 0, 8'h00);
            chk("sat_seq", cnt2, (i + 1 > 3) ? 3 : i + 1);
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                wr(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            xact(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        // Final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
